// File: rtl/pipe_ctrl_sb.sv
// Scoreboard pipeline controller: per-register latency interlock and irq drain FSM.
// Optional WFI wait-for-interrupt stall is enabled by defining PIPE_CTRL_WFI_EN.
module pipe_ctrl_sb #(
  parameter int NREG    = 32,
  parameter int MAX_LAT = 7,
  parameter int XLEN    = 32,
  localparam int AW     = $clog2(NREG),
  localparam int LW     = $clog2(MAX_LAT + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_valid_i,
  input  logic            id_op1_is_reg_i,
  input  logic            id_op2_is_reg_i,
  input  logic [AW-1:0]   id_rs1_i,
  input  logic [AW-1:0]   id_rs2_i,
  input  logic [AW-1:0]   id_rd_i,
  input  logic            id_reg_write_i,
  input  logic [LW-1:0]   id_lat_i,
  input  logic            ex_branch_jump_i,
  input  logic [XLEN-1:0] ex_jump_addr_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic            ex_mret_i,
  input  logic            ex_wfi_i,
  input  logic            irq_pending_i,
  input  logic            irq_wake_en_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            L1IC_core_wait_i,
  input  logic            L1DC_core_wait_i,
  output logic            L1IC_core_req_o,
  output logic            if_pc_stall_o,
  output logic            id_stall_o,
  output logic            ex_stall_o,
  output logic            mem_stall_o,
  output logic            wb_stall_o,
  output logic            id_bubble_o,
  output logic            ex_bubble_o,
  output logic            if_pc_flush_o,
  output logic [XLEN-1:0] if_pc_flush_addr_o,
  output logic            interrupt_taken_o,
  output logic            interrupt_return_o,
  output logic [XLEN-1:0] interrupt_mepc_o,
  output logic [NREG-1:0] sb_busy_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, TRAP} state_t;

  state_t        state;
  logic [LW-1:0] cnt [NREG];
  logic          rst_done;
  logic          glob, drain, trap;
  logic          raw, cand, waw, wfi_hold;
  logic          issue, all_clear;
  logic [LW-1:0] lat_eff;

  assign glob  = L1DC_core_wait_i | ~rst_done;
  assign drain = (state == DRAIN);
  assign trap  = (state == TRAP);

  assign lat_eff = (id_lat_i > LW'(MAX_LAT)) ? LW'(MAX_LAT) : id_lat_i;

  always_comb begin
    for (int r = 0; r < NREG; r++) sb_busy_o[r] = (cnt[r] != '0);
  end
  assign all_clear = ~|sb_busy_o;

  assign raw = (id_op1_is_reg_i && id_rs1_i != '0 && cnt[id_rs1_i] > LW'(1))
            || (id_op2_is_reg_i && id_rs2_i != '0 && cnt[id_rs2_i] > LW'(1));
  assign cand = id_valid_i & id_reg_write_i & (id_rd_i != '0);
  assign waw  = cand && (cnt[id_rd_i] > id_lat_i);

`ifdef PIPE_CTRL_WFI_EN
  assign wfi_hold = ex_wfi_i & irq_wake_en_i & ~trap;
`else
  logic unused_wfi;
  assign unused_wfi = ex_wfi_i ^ irq_wake_en_i;
  assign wfi_hold   = 1'b0;
`endif

  // TRAP releases the front end so the trapping instruction gets flushed
  assign if_pc_stall_o = glob
    | (~trap & (raw | waw | L1IC_core_wait_i | drain | wfi_hold));
  assign id_stall_o  = if_pc_stall_o;
  assign ex_stall_o  = glob | (~trap & (drain | wfi_hold));
  assign mem_stall_o = glob;
  assign wb_stall_o  = glob;

  always_comb begin
    if_pc_flush_o      = 1'b0;
    if_pc_flush_addr_o = '0;
    interrupt_taken_o  = 1'b0;
    interrupt_return_o = 1'b0;
    interrupt_mepc_o   = '0;
    if (rst_done) begin
      if (trap) begin
        if_pc_flush_o      = 1'b1;
        if_pc_flush_addr_o = mtvec_i;
        interrupt_taken_o  = 1'b1;
        if (ex_branch_jump_i) interrupt_mepc_o = ex_jump_addr_i;
`ifdef PIPE_CTRL_WFI_EN
        else if (ex_wfi_i)    interrupt_mepc_o = ex_pc_i + XLEN'(4);
`endif
        else                  interrupt_mepc_o = ex_pc_i;
      end else if (~drain && ex_branch_jump_i
                   && ex_jump_addr_i != id_pc_i) begin
        if_pc_flush_o      = 1'b1;
        if_pc_flush_addr_o = ex_jump_addr_i;
      end else if (~drain && ex_mret_i) begin
        if_pc_flush_o      = 1'b1;
        if_pc_flush_addr_o = mepc_i;
        interrupt_return_o = 1'b1;
      end
    end
  end

  assign id_bubble_o     = if_pc_flush_o;
  assign ex_bubble_o     = if_pc_flush_o | (ex_stall_o & ~mem_stall_o);
  assign L1IC_core_req_o = rst_done & ~if_pc_flush_o;

  assign issue = cand & ~id_stall_o & ~id_bubble_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      state    <= IDLE;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      for (int r = 0; r < NREG; r++) begin
        if (issue && id_rd_i == AW'(r))
          cnt[r] <= lat_eff;
        else if (cnt[r] != '0 && ~mem_stall_o)
          cnt[r] <= cnt[r] - LW'(1);
      end
      unique case (state)
        IDLE:  if (irq_pending_i) state <= DRAIN;
        DRAIN: begin
          if (~irq_pending_i) state <= IDLE;
          else if (all_clear) state <= TRAP;
        end
        TRAP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
